// File: rtl/four_channel_request_latch_pkg.sv
// Shared constants and types for the four-channel request latch and the
// downstream 4:2 priority encoder bench.
package four_channel_request_latch_pkg;

  localparam int NUM_CH = 4;

  localparam int CH_A = 0;
  localparam int CH_B = 1;
  localparam int CH_C = 2;
  localparam int CH_D = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  // One-hot of the highest set bit; channel D has the highest priority.
  function automatic logic [NUM_CH-1:0] pick_highest(input logic [NUM_CH-1:0] req);
    logic [NUM_CH-1:0] grant;
    grant = '0;
    if (req[CH_D])      grant[CH_D] = 1'b1;
    else if (req[CH_C]) grant[CH_C] = 1'b1;
    else if (req[CH_B]) grant[CH_B] = 1'b1;
    else if (req[CH_A]) grant[CH_A] = 1'b1;
    return grant;
  endfunction

endpackage

// File: rtl/four_channel_request_latch_sync.sv
// request_sync_edge: multi-flop synchronizer for one asynchronous request
// line followed by a single-cycle rising-edge detector.
module request_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   prev_q;
  logic                   armed_q;

  // fill_q tracks which synchronizer stages hold real samples rather than
  // reset zeros; the detector arms only after a genuine low has been seen,
  // so a line already high when reset releases produces no event.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (reset) begin
      sync_q  <= '0;
      fill_q  <= '0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      prev_q <= sync_q[SYNC_STAGES-1];
      if (fill_q[SYNC_STAGES-1] && !sync_q[SYNC_STAGES-1]) armed_q <= 1'b1;
    end
  end

  assign rise = armed_q & sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/four_channel_request_latch.sv
// Latches four asynchronous request lines and offers them one at a time,
// highest priority first, over a valid/ready handshake.
module four_channel_request_latch
  import four_channel_request_latch_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a,
  input  logic              b,
  input  logic              c,
  input  logic              d,
  output logic [NUM_CH-1:0] req_out,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] overrun,
  input  logic              clr_overrun
);

  logic [NUM_CH-1:0] req_in;
  logic [NUM_CH-1:0] evt;
  logic [NUM_CH-1:0] xfer_mask;
  logic [NUM_CH-1:0] ovr_set;
  logic [NUM_CH-1:0] req_out_d;
  logic              transfer;
  state_t            state_q;
  state_t            state_d;

  assign req_in = {d, c, b, a};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    request_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .reset (reset),
      .din   (req_in[i]),
      .rise  (evt[i])
    );
  end

  assign req_valid = (state_q == OFFER);
  assign transfer  = req_valid & req_ready;
  assign xfer_mask = transfer ? req_out : '0;

  // A fresh event on the channel being accepted re-latches it; elsewhere it
  // is lost against an already-pending bit and flagged.
  assign ovr_set = evt & pending & ~xfer_mask;

  always_comb begin
    // NOTE: defaults first so every path assigns every output, avoiding latches.
    state_d   = state_q;
    req_out_d = req_out;
    case (state_q)
      IDLE: begin
        if (pending != '0) begin
          state_d   = OFFER;
          req_out_d = pick_highest(pending);
        end
      end
      OFFER: begin
        if (req_ready) begin
          state_d   = IDLE;
          req_out_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_out <= '0;
      pending <= '0;
      overrun <= '0;
    end else begin
      state_q <= state_d;
      req_out <= req_out_d;
      pending <= (pending & ~xfer_mask) | evt;
      overrun <= clr_overrun ? ovr_set : (overrun | ovr_set);
    end
  end

endmodule

// File: doc/four_channel_request_latch.md
FOUR_CHANNEL_REQUEST_LATCH -- requirements
Module: four_channel_request_latch

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, giving the number of synchronizer flops per request input (legal range 2..4).
REQ-002 The block SHALL have port clk, input, 1 bit, the single rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-004 The block SHALL have port a, input, 1 bit, asynchronous request source 0 (lowest priority).
REQ-005 The block SHALL have port b, input, 1 bit, asynchronous request source 1.
REQ-006 The block SHALL have port c, input, 1 bit, asynchronous request source 2.
REQ-007 The block SHALL have port d, input, 1 bit, asynchronous request source 3 (highest priority).
REQ-008 The block SHALL have port req_out, output, 4 bits, one-hot offered request ordered {d,c,b,a}, feeding the downstream 4:2 priority encoder.
REQ-009 The block SHALL have port req_valid, output, 1 bit, high when req_out carries an offered request.
REQ-010 The block SHALL have port req_ready, input, 1 bit, downstream acceptance; a transfer occurs on a cycle with req_valid and req_ready both high.
REQ-011 The block SHALL have port pending, output, 4 bits, latched-but-unaccepted requests ordered {d,c,b,a}.
REQ-012 The block SHALL have port overrun, output, 4 bits, sticky per-channel flag for a request lost while already pending.
REQ-013 The block SHALL have port clr_overrun, input, 1 bit, synchronous clear of all overrun bits.

Function
REQ-014 Each of a..d SHALL pass through SYNC_STAGES flops; a rising edge on the last flop's output (0 in the previous cycle, 1 now) SHALL count as one event.
REQ-015 An event SHALL set the channel's pending bit on the next clock; latency from the input pin to pending is SYNC_STAGES+1 cycles.
REQ-016 A level held high SHALL produce exactly one event; the input must return low before it can produce another.
REQ-017 The FSM SHALL have two states: IDLE and OFFER.
REQ-018 IDLE: req_valid=0 and req_out=4'b0000; if pending is nonzero, the FSM SHALL go to OFFER on the next clock, freezing req_out to the highest-priority pending bit (d>c>b>a).
REQ-019 OFFER: req_valid=1; req_out SHALL stay stable until a transfer occurs, even if a higher-priority request arrives.
REQ-020 On a transfer, the offered channel's pending bit SHALL clear on the next clock and the FSM SHALL return to IDLE; back-to-back offers are therefore separated by exactly one IDLE cycle, with req_out=0000.
REQ-021 If an event occurs on a channel whose pending bit is already set and that channel is not being transferred this cycle, the pending bit SHALL stay set and the channel's overrun bit SHALL set.
REQ-022 If an event occurs on the channel being transferred in the same cycle, the pending bit SHALL remain set (the new event is retained) and overrun SHALL NOT set.
REQ-023 Simultaneous events on several channels SHALL all set their pending bits in the same cycle.
REQ-024 clr_overrun SHALL clear overrun on the next clock; if an overrun condition occurs in the same cycle, the set SHALL win.
REQ-025 req_ready while in IDLE SHALL have no effect.

Reset
REQ-026 While reset is high at a clock edge, the block SHALL clear all synchronizer flops, edge-history flops, pending, overrun and req_out to 0, and set the FSM to IDLE (req_valid=0).
REQ-027 A reset asserted during OFFER SHALL discard the offered request without a transfer; the events present in the synchronizers at that time are lost.
REQ-028 After reset, inputs already held high SHALL NOT generate an event until they go low and high again.

Structure
REQ-029 The FSM state encoding, the channel-index constants (A=0..D=3) and the width constant 4 SHALL live in a shared package used by this block and the encoder bench.
REQ-030 One sub-module, request_sync_edge (synchronizer plus rising-edge detector, parameterized by SYNC_STAGES), SHALL be instantiated four times; all other logic SHALL be in the top module.

Verification
REQ-031 Reset, then pulse c high for 3 cycles with req_ready=1 -> pending=0100 after 3 cycles, req_out=0100 with req_valid=1 for 1 cycle, then pending=0000.
REQ-032 Raise a,b,d in the same cycle with req_ready=1 -> offers 1000, 0010, 0001 in that order, each separated by one req_valid=0 cycle.
REQ-033 Hold req_ready=0, pulse a, then pulse d -> req_out stays 0001 until req_ready=1, then 1000 is offered.
REQ-034 Hold req_ready=0, pulse b twice -> pending=0010 and overrun=0010; pulse clr_overrun -> overrun=0000 while pending stays 0010.
REQ-035 Pulse a so its event lands in the transfer cycle of an offered a -> pending[0] stays 1, overrun[0] stays 0, and a is offered again.
REQ-036 Assert reset during OFFER of 0100 -> the next cycle shows req_valid=0, pending=0000 and overrun=0000.
